// File: rtl/dag_if.sv
// rtl/dag_if.sv - sequencer/bus-connect side signals of the data address generator
interface dag_if #(parameter int AW = 16);
  logic          ps_dg_en;
  logic          ps_dg_dgsclt;
  logic          ps_dg_mdfy;
  logic [2:0]    ps_dg_iadd;
  logic [2:0]    ps_dg_madd;
  logic          ps_dg_wrt_en;
  logic [4:0]    ps_dg_wrt_add;
  logic [4:0]    ps_dg_rd_add;
  logic [AW-1:0] bc_dt;
  logic [AW-1:0] dg_bc_dt;
  logic [AW-1:0] dg_dm_add;
  logic          dg_dm_vld;
  logic [AW-1:0] dg_ps_add;
  logic          dg_ps_vld;

  modport master (
    output ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
           ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    input  dg_bc_dt, dg_dm_add, dg_dm_vld, dg_ps_add, dg_ps_vld
  );

  modport slave (
    input  ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
           ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    output dg_bc_dt, dg_dm_add, dg_dm_vld, dg_ps_add, dg_ps_vld
  );
endinterface

// File: rtl/dag_unit.sv
// rtl/dag_unit.sv - data address generator with I/M (and optional L/B) ureg file
// Define DAG_CIRC_BUF_EN to implement L/B registers and circular addressing.
module dag_unit #(
  parameter int AW = 16
) (
  input logic clk,
  input logic rst,
  dag_if.slave bus
);
  typedef logic [AW-1:0] word_t;

  word_t i_reg [8];
  word_t m_reg [8];
`ifdef DAG_CIRC_BUF_EN
  word_t l_reg [8];
  word_t b_reg [8];
  word_t l_cur;
  word_t b_cur;
`endif
  word_t i_cur;
  word_t m_cur;
  word_t sum;
  word_t mod_val;
  word_t acc_addr;
  word_t rd_val;
  word_t dm_add_q;
  word_t ps_add_q;
  logic  dm_vld_q;
  logic  ps_vld_q;

  always_comb begin
    i_cur   = i_reg[bus.ps_dg_iadd];
    m_cur   = m_reg[bus.ps_dg_madd];
    sum     = i_cur + m_cur;
    mod_val = sum;
`ifdef DAG_CIRC_BUF_EN
    l_cur = l_reg[bus.ps_dg_iadd];
    b_cur = b_reg[bus.ps_dg_iadd];
    // One wrap step only; the upper bound needs the 17th bit when B+L overflows.
    if (l_cur != '0) begin
      if ({1'b0, sum} >= ({1'b0, b_cur} + {1'b0, l_cur}))
        mod_val = sum - l_cur;
      else if (sum < b_cur)
        mod_val = sum + l_cur;
    end
`endif
    acc_addr = bus.ps_dg_mdfy ? i_cur : mod_val;
  end

  always_comb begin
    rd_val = '0;
    case (bus.ps_dg_rd_add[4:3])
      2'b00:   rd_val = i_reg[bus.ps_dg_rd_add[2:0]];
      2'b01:   rd_val = m_reg[bus.ps_dg_rd_add[2:0]];
`ifdef DAG_CIRC_BUF_EN
      2'b10:   rd_val = l_reg[bus.ps_dg_rd_add[2:0]];
      2'b11:   rd_val = b_reg[bus.ps_dg_rd_add[2:0]];
`endif
      default: rd_val = '0;
    endcase
    if (bus.ps_dg_wrt_en && (bus.ps_dg_wrt_add == bus.ps_dg_rd_add))
      rd_val = bus.bc_dt;
  end

  assign bus.dg_bc_dt  = rd_val;
  assign bus.dg_dm_add = dm_add_q;
  assign bus.dg_dm_vld = dm_vld_q;
  assign bus.dg_ps_add = ps_add_q;
  assign bus.dg_ps_vld = ps_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
`ifdef DAG_CIRC_BUF_EN
        l_reg[k] <= '0;
        b_reg[k] <= '0;
`endif
      end
      dm_add_q <= '0;
      ps_add_q <= '0;
      dm_vld_q <= 1'b0;
      ps_vld_q <= 1'b0;
    end else begin
      if (bus.ps_dg_en && bus.ps_dg_mdfy)
        i_reg[bus.ps_dg_iadd] <= mod_val;
      // Placed after the modify update so a ureg write to the same I wins.
      if (bus.ps_dg_wrt_en) begin
        case (bus.ps_dg_wrt_add[4:3])
          2'b00:   i_reg[bus.ps_dg_wrt_add[2:0]] <= bus.bc_dt;
          2'b01:   m_reg[bus.ps_dg_wrt_add[2:0]] <= bus.bc_dt;
`ifdef DAG_CIRC_BUF_EN
          2'b10:   l_reg[bus.ps_dg_wrt_add[2:0]] <= bus.bc_dt;
          2'b11:   b_reg[bus.ps_dg_wrt_add[2:0]] <= bus.bc_dt;
`endif
          default: ;
        endcase
      end
      dm_vld_q <= bus.ps_dg_en && !bus.ps_dg_dgsclt;
      ps_vld_q <= bus.ps_dg_en && bus.ps_dg_dgsclt;
      if (bus.ps_dg_en && !bus.ps_dg_dgsclt)
        dm_add_q <= acc_addr;
      if (bus.ps_dg_en && bus.ps_dg_dgsclt)
        ps_add_q <= acc_addr;
    end
  end
endmodule

// File: tb/tb_dag_unit.sv
// tb/tb_dag_unit.sv - vector table, corner sequences and random run against a reference model
module tb_dag_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dag_if #(.AW(16)) bus ();
  dag_unit #(.AW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        en, sel, mdfy;
    logic [2:0]  iadd, madd;
    logic        wen;
    logic [4:0]  wadd, radd;
    logic [15:0] data;
  } ctl_t;

  typedef struct {
    ctl_t        c;
    logic [15:0] rd;
    logic        dmv;
    logic [15:0] dma;
    logic        psv;
    logic [15:0] psa;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  int mi [8];
  int mm [8];
  int ml [8];
  int mb [8];
  int mdma, mpsa, mdmv, mpsv;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic ctl_t mkc(input bit en, input bit sel, input bit mdfy, input int iadd,
                               input int madd, input bit wen, input int wadd, input int radd,
                               input int data);
    ctl_t c;
    c.en = en; c.sel = sel; c.mdfy = mdfy;
    c.iadd = 3'(iadd); c.madd = 3'(madd);
    c.wen = wen; c.wadd = 5'(wadd); c.radd = 5'(radd); c.data = 16'(data);
    return c;
  endfunction

  function automatic vec_t mkv(input ctl_t c, input int rd, input bit dmv, input int dma,
                               input bit psv, input int psa);
    vec_t v;
    v.c = c; v.rd = 16'(rd); v.dmv = dmv; v.dma = 16'(dma); v.psv = psv; v.psa = 16'(psa);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      mi[k] = 0; mm[k] = 0; ml[k] = 0; mb[k] = 0;
    end
    mdma = 0; mpsa = 0; mdmv = 0; mpsv = 0;
  endtask

  function automatic int model_rd(input ctl_t c);
    int grp, idx;
    grp = int'(c.radd) / 8;
    idx = int'(c.radd) % 8;
    if (c.wen && c.wadd == c.radd) return int'(c.data);
    if (grp == 0) return mi[idx];
    if (grp == 1) return mm[idx];
`ifdef DAG_CIRC_BUF_EN
    if (grp == 2) return ml[idx];
    return mb[idx];
`else
    return 0;
`endif
  endfunction

  task automatic model_step(input ctl_t c);
    int s, addr, grp, idx;
    s = (mi[c.iadd] + mm[c.madd]) % 65536;
    if (ml[c.iadd] != 0) begin
      if (s >= mb[c.iadd] + ml[c.iadd]) s = s - ml[c.iadd];
      else if (s < mb[c.iadd]) s = s + ml[c.iadd];
      s = s % 65536;
    end
    addr = c.mdfy ? mi[c.iadd] : s;
    if (c.en && c.mdfy) mi[c.iadd] = s;
    if (c.wen) begin
      grp = int'(c.wadd) / 8;
      idx = int'(c.wadd) % 8;
      if (grp == 0) mi[idx] = int'(c.data);
      if (grp == 1) mm[idx] = int'(c.data);
`ifdef DAG_CIRC_BUF_EN
      if (grp == 2) ml[idx] = int'(c.data);
      if (grp == 3) mb[idx] = int'(c.data);
`endif
    end
    mdmv = (c.en && !c.sel) ? 1 : 0;
    mpsv = (c.en && c.sel) ? 1 : 0;
    if (c.en && !c.sel) mdma = addr;
    if (c.en && c.sel) mpsa = addr;
  endtask

  task automatic drive(input ctl_t c);
    bus.ps_dg_en      = c.en;
    bus.ps_dg_dgsclt  = c.sel;
    bus.ps_dg_mdfy    = c.mdfy;
    bus.ps_dg_iadd    = c.iadd;
    bus.ps_dg_madd    = c.madd;
    bus.ps_dg_wrt_en  = c.wen;
    bus.ps_dg_wrt_add = c.wadd;
    bus.ps_dg_rd_add  = c.radd;
    bus.bc_dt         = c.data;
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic run_cycle(input ctl_t c, output logic [15:0] rd, output logic dmv,
                           output logic [15:0] dma, output logic psv, output logic [15:0] psa);
    drive(c);
    #1;
    rd = bus.dg_bc_dt;
    chk("model_rd", int'(rd), model_rd(c));
    @(posedge clk);
    model_step(c);
    #1;
    dmv = bus.dg_dm_vld; dma = bus.dg_dm_add;
    psv = bus.dg_ps_vld; psa = bus.dg_ps_add;
    chk("model_dm_vld", int'(dmv), mdmv);
    chk("model_dm_add", int'(dma), mdma);
    chk("model_ps_vld", int'(psv), mpsv);
    chk("model_ps_add", int'(psa), mpsa);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dm_vld"}, int'(bus.dg_dm_vld), 0);
    chk({tag, "_ps_vld"}, int'(bus.dg_ps_vld), 0);
    chk({tag, "_dm_add"}, int'(bus.dg_dm_add), 0);
    chk({tag, "_ps_add"}, int'(bus.dg_ps_add), 0);
    for (int r = 0; r < 32; r++) begin
      bus.ps_dg_rd_add = 5'(r);
      #1;
      chk($sformatf("%s_reg%0d", tag, r), int'(bus.dg_bc_dt), 0);
    end
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 18;
`ifdef DAG_CIRC_BUF_EN
  localparam int L_EXP = 16'h5555;
`else
  localparam int L_EXP = 0;
`endif

  vec_t tbl [NV];
  logic [15:0] rd, dma, psa;
  logic dmv, psv;
  ctl_t c;

  initial begin
    tbl[0]  = mkv(mkc(0,0,0,0,0,1,2,2,'h0100),    'h0100, 0,'h0000, 0,'h0000);
    tbl[1]  = mkv(mkc(0,0,0,0,0,1,13,2,'h0004),   'h0100, 0,'h0000, 0,'h0000);
    tbl[2]  = mkv(mkc(1,0,1,2,5,0,0,2,0),         'h0100, 1,'h0100, 0,'h0000);
    tbl[3]  = mkv(mkc(0,0,0,0,0,0,0,2,0),         'h0104, 0,'h0100, 0,'h0000);
    tbl[4]  = mkv(mkc(1,0,1,2,5,0,0,2,0),         'h0104, 1,'h0104, 0,'h0000);
    tbl[5]  = mkv(mkc(0,0,0,0,0,0,0,2,0),         'h0108, 0,'h0104, 0,'h0000);
    tbl[6]  = mkv(mkc(0,0,0,0,0,1,1,1,'h0FFE),    'h0FFE, 0,'h0104, 0,'h0000);
    tbl[7]  = mkv(mkc(0,0,0,0,0,1,8,8,'hFFFE),    'hFFFE, 0,'h0104, 0,'h0000);
    tbl[8]  = mkv(mkc(1,1,0,1,0,0,0,1,0),         'h0FFE, 0,'h0104, 1,'h0FFC);
    tbl[9]  = mkv(mkc(0,0,0,0,0,0,0,1,0),         'h0FFE, 0,'h0104, 0,'h0FFC);
    tbl[10] = mkv(mkc(0,0,0,0,0,1,3,3,'hFFFF),    'hFFFF, 0,'h0104, 0,'h0FFC);
    tbl[11] = mkv(mkc(0,0,0,0,0,1,11,11,'h0002),  'h0002, 0,'h0104, 0,'h0FFC);
    tbl[12] = mkv(mkc(1,0,1,3,3,0,0,3,0),         'hFFFF, 1,'hFFFF, 0,'h0FFC);
    tbl[13] = mkv(mkc(0,0,0,0,0,0,0,3,0),         'h0001, 0,'hFFFF, 0,'h0FFC);
    tbl[14] = mkv(mkc(1,0,1,2,5,1,2,2,'h1234),    'h1234, 1,'h0108, 0,'h0FFC);
    tbl[15] = mkv(mkc(0,0,0,0,0,0,0,2,0),         'h1234, 0,'h0108, 0,'h0FFC);
    tbl[16] = mkv(mkc(0,0,0,0,0,1,16,2,'h5555),   'h1234, 0,'h0108, 0,'h0FFC);
    tbl[17] = mkv(mkc(0,0,0,0,0,0,0,16,0),        L_EXP,  0,'h0108, 0,'h0FFC);

    drive(mkc(0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    for (int k = 0; k < NV; k++) begin
      run_cycle(tbl[k].c, rd, dmv, dma, psv, psa);
      chk($sformatf("vec%0d_rd", k),  int'(rd),  int'(tbl[k].rd));
      chk($sformatf("vec%0d_dmv", k), int'(dmv), int'(tbl[k].dmv));
      chk($sformatf("vec%0d_dma", k), int'(dma), int'(tbl[k].dma));
      chk($sformatf("vec%0d_psv", k), int'(psv), int'(tbl[k].psv));
      chk($sformatf("vec%0d_psa", k), int'(psa), int'(tbl[k].psa));
    end

`ifdef DAG_CIRC_BUF_EN
    run_cycle(mkc(0,0,0,0,0,1,24,0,'h0200), rd, dmv, dma, psv, psa);
    run_cycle(mkc(0,0,0,0,0,1,16,0,'h0010), rd, dmv, dma, psv, psa);
    run_cycle(mkc(0,0,0,0,0,1,0,0,'h020E),  rd, dmv, dma, psv, psa);
    run_cycle(mkc(0,0,0,0,0,1,8,0,'h0004),  rd, dmv, dma, psv, psa);
    run_cycle(mkc(1,0,1,0,0,0,0,0,0),       rd, dmv, dma, psv, psa);
    chk("circ_up_addr", int'(dma), 'h020E);
    chk("circ_up_vld", int'(dmv), 1);
    run_cycle(mkc(0,0,0,0,0,1,8,0,'hFFF0),  rd, dmv, dma, psv, psa);
    chk("circ_up_i0", int'(rd), 'h0202);
    run_cycle(mkc(1,0,1,0,0,0,0,0,0),       rd, dmv, dma, psv, psa);
    chk("circ_dn_addr", int'(dma), 'h0202);
    run_cycle(mkc(0,0,0,0,0,0,0,0,0),       rd, dmv, dma, psv, psa);
    chk("circ_dn_i0", int'(rd), 'h0202);
`endif

    for (int n = 0; n < 400; n++) begin
      c = mkc($urandom_range(0,1) == 0, $urandom_range(0,1) == 1, $urandom_range(0,1) == 1,
              $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,2) == 0,
              $urandom_range(0,31), $urandom_range(0,31), $urandom_range(0,65535));
      if ($urandom_range(0,7) == 0) c.radd = c.wadd;
      run_cycle(c, rd, dmv, dma, psv, psa);
    end

    run_cycle(mkc(0,0,0,0,0,1,9,0,'h0003), rd, dmv, dma, psv, psa);
    run_cycle(mkc(0,0,0,0,0,1,4,0,'h4000), rd, dmv, dma, psv, psa);
    drive(mkc(1,0,1,4,1,0,0,0,0));
    @(posedge clk);
    #1;
    drive(mkc(0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all_zero("midrst");

    run_cycle(mkc(1,1,1,0,0,0,0,0,0), rd, dmv, dma, psv, psa);
    chk("post_rst_psv", int'(psv), 1);
    chk("post_rst_dmv", int'(dmv), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
